// File: rtl/pipeline_control_unit.sv
`timescale 1ns/1ps
// pipeline_control_unit: central stall/flush sequencer for the 5-stage core.
// Turns load-use, branch, data-memory and halt events into stage enables and bubbles.
module pipeline_control_unit #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FRZ_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  // What the pipeline does this cycle, independent of which state got us here.
  typedef enum logic [1:0] {ACT_IDLE, ACT_FROZEN, ACT_RUN, ACT_DRAIN} action_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [FRZ_W-1:0] frz_q, frz_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  action_t          act;
  logic             freeze;
  logic             stall_inc;
  logic             flush_inc;
  logic             go_timeout;

  assign freeze = dmem_req && !dmem_ready;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    ret_d       = ret_q;
    frz_d       = frz_q;
    drain_d     = drain_q;
    act         = ACT_IDLE;
    go_timeout  = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    case (state_q)
      RUN, DRAIN: begin
        if (freeze) begin
          // The entry cycle is frozen cycle 1; the wait remembers where to resume.
          act     = ACT_FROZEN;
          state_d = MEM_WAIT;
          ret_d   = state_q;
          frz_d   = FRZ_W'(1);
        end else begin
          act = (state_q == DRAIN) ? ACT_DRAIN : ACT_RUN;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          act = ACT_FROZEN;
          if (frz_q == FRZ_W'(MEM_TIMEOUT - 1)) begin
            state_d    = HALTED;
            go_timeout = 1'b1;
          end else begin
            frz_d = frz_q + 1'b1;
          end
        end else begin
          state_d = ret_q;
          act     = (ret_q == DRAIN) ? ACT_DRAIN : ACT_RUN;
        end
      end
      default: act = ACT_IDLE;
    endcase

    case (act)
      ACT_FROZEN: stall_inc = 1'b1;
      ACT_RUN: begin
        if (branch_taken) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (halt_req) begin
          {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
          if_id_flush = 1'b1;
          state_d     = DRAIN;
          drain_d     = DRN_W'(1);
        end else if (load_use_hazard) begin
          // Hold PC and IF/ID, push one bubble into ID/EX.
          {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        end
      end
      ACT_DRAIN: begin
        {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
        if_id_flush = 1'b1;
        if (drain_q == DRN_W'(DRAIN_CYCLES)) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Enables are combinational, so they must be forced low while reset is held.
    if (!reset_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      ret_q        <= RUN;
      frz_q        <= '0;
      drain_q      <= '0;
      halted       <= 1'b0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      ret_q   <= ret_d;
      frz_q   <= frz_d;
      drain_q <= drain_d;
      if (state_d == HALTED) halted      <= 1'b1;
      if (go_timeout)        timeout_err <= 1'b1;
      if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_inc && (flush_count != '1))  flush_count  <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for pipeline_control_unit: directed scenarios plus random traffic,
// expected responses come from a cycle-level behavioural model of the control rules.
module tb_pipeline_control_unit;

  localparam int MEM_TIMEOUT  = 16;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 5;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // ctrl = {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  typedef struct packed {
    logic [6:0]       ctrl;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } obs_t;

  localparam logic [6:0] C_NORMAL = 7'b1111100;
  localparam logic [6:0] C_BRANCH = 7'b1111111;
  localparam logic [6:0] C_DRAIN  = 7'b0111110;
  localparam logic [6:0] C_LDUSE  = 7'b0011101;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic load_use_hazard = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0;
  logic dmem_ready = 1'b0, halt_req = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic halted, timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  pipeline_control_unit #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .load_use_hazard(load_use_hazard),
    .branch_taken   (branch_taken),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .halt_req       (halt_req),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .halted         (halted),
    .timeout_err    (timeout_err),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: what has happened so far, in plain counts.
  bit m_halted, m_timeout, m_draining;
  int m_stall, m_flush, m_drain_done, m_frozen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  task automatic model(input logic rst_n, input logic lu, input logic br, input logic dreq,
                       input logic drdy, input logic hr, output obs_t e);
    bit frozen;
    int n;
    e = '0;
    if (!rst_n) begin
      m_halted = 0; m_timeout = 0; m_draining = 0;
      m_stall = 0; m_flush = 0; m_drain_done = 0; m_frozen = 0;
      return;
    end
    e.halted      = m_halted;
    e.timeout_err = m_timeout;
    e.stall       = CNT_W'(m_stall);
    e.flush       = CNT_W'(m_flush);
    if (m_halted) return;
    // Once waiting, only ready matters; a new wait needs an outstanding request.
    frozen = (m_frozen > 0) ? !drdy : (dreq && !drdy);
    if (frozen) begin
      n = m_frozen + 1;
      m_stall = sat_inc(m_stall);
      if (n >= MEM_TIMEOUT) begin
        m_halted = 1; m_timeout = 1; m_frozen = 0;
      end else begin
        m_frozen = n;
      end
    end else begin
      m_frozen = 0;
      if (m_draining) begin
        e.ctrl = C_DRAIN;
        m_drain_done++;
        if (m_drain_done == DRAIN_CYCLES) m_halted = 1;
      end else if (br) begin
        e.ctrl  = C_BRANCH;
        m_flush = sat_inc(m_flush);
      end else if (hr) begin
        e.ctrl       = C_DRAIN;
        m_draining   = 1;
        m_drain_done = 0;
      end else if (lu) begin
        e.ctrl  = C_LDUSE;
        m_stall = sat_inc(m_stall);
      end else begin
        e.ctrl = C_NORMAL;
      end
    end
  endtask

  task automatic step(input logic rst_n, input logic lu, input logic br, input logic dreq,
                      input logic drdy, input logic hr);
    obs_t e;
    reset_n         = rst_n;
    load_use_hazard = lu;
    branch_taken    = br;
    dmem_req        = dreq;
    dmem_ready      = drdy;
    halt_req        = hr;
    model(rst_n, lu, br, dreq, drdy, hr, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT against the oldest expectation on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
             halted, timeout_err, stall_cycles, flush_count};
        check($sformatf("ctrl c%0d", cyc), 32'(a.ctrl), 32'(e.ctrl));
        check($sformatf("status c%0d", cyc), 32'({a.halted, a.timeout_err}),
              32'({e.halted, e.timeout_err}));
        check($sformatf("counters c%0d", cyc), 32'({a.stall, a.flush}), 32'({e.stall, e.flush}));
        cyc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_q[0]);
    exp_q.delete();
    #2;
    check("reset_ctrl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                             if_id_flush, id_ex_flush}), 32'd0);
    check("reset_status", 32'({halted, timeout_err, stall_cycles, flush_count}), 32'd0);
    #4;

    idle(2);
    // Single load-use bubble, then branch with a simultaneous load-use.
    step(1, 1, 0, 0, 0, 0); idle(1);
    step(1, 1, 1, 0, 0, 0); idle(1);
    // Three frozen cycles, ready in the fourth.
    repeat (3) step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0); idle(2);
    // Halt with a branch in drain cycle 1 and a two-cycle freeze in drain cycle 2.
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 0); idle(2);
    // Memory timeout, then sticky status with traffic still applied.
    repeat (18) step(1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1, 1); idle(2);
    step(0, 0, 0, 0, 0, 0); idle(1);
    // Reset in the middle of a drain and in the middle of a memory wait.
    step(1, 0, 0, 0, 0, 1); idle(1);
    step(0, 0, 0, 0, 0, 0); idle(2);
    step(1, 0, 0, 1, 0, 0); step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0); idle(1);
    // Freeze masks a branch; branch honoured only if still present at release.
    step(1, 0, 1, 1, 0, 0); step(1, 0, 1, 1, 1, 0);
    step(1, 0, 1, 1, 0, 0); step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0); step(1, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 1, 0);
    idle(1);
    // Counter saturation.
    repeat (40) step(1, 1, 0, 0, 0, 0);
    repeat (40) step(1, 0, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0); idle(1);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 24) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
